// File: rtl/adder_operand_packer_if.sv
// Bus bundle for adder_operand_packer.
//   Serial side : s_valid, s_ready, s_data, s_last (valid/ready stream of BITS-wide operands)
//   Group side  : out_valid, out_ready, out_data, out_count, out_last (one packed group)
// Modports:
//   slave  - the packer itself (consumes the serial stream, produces groups)
//   master - the environment (operand source plus group consumer)
interface adder_operand_packer_if #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NUM  = 4
);
    localparam int unsigned CntW = $clog2(NUM + 1);

    logic                 s_valid;
    logic                 s_ready;
    logic [BITS-1:0]      s_data;
    logic                 s_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM*BITS-1:0]  out_data;
    logic [CntW-1:0]      out_count;
    logic                 out_last;

    modport slave (
        input  s_valid, s_data, s_last, out_ready,
        output s_ready, out_valid, out_data, out_count, out_last
    );

    modport master (
        output s_valid, s_data, s_last, out_ready,
        input  s_ready, out_valid, out_data, out_count, out_last
    );
endinterface

// File: rtl/adder_operand_packer.sv
// Packs a serial stream of BITS-wide operands into groups of NUM parallel operands for the
// multi-input adder. A group closed early by s_last is padded with PAD_VALUE.
// Ports:
//   clk     - clock, all state on posedge
//   resetn  - synchronous active-low reset
//   bus     - adder_operand_packer_if.slave: serial operand stream in, packed group out
//             (out_data = {op0, op1, .., op(NUM-1)}, op0 in the MSBs)
module adder_operand_packer #(
    parameter int unsigned     BITS      = 16,
    parameter int unsigned     NUM       = 4,
    parameter logic [BITS-1:0] PAD_VALUE = '0
) (
    input logic                   clk,
    input logic                   resetn,
    adder_operand_packer_if.slave bus
);
    localparam int unsigned IdxW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned CntW = $clog2(NUM + 1);

    // Assembly stage
    logic [BITS-1:0]     slot_q [NUM];
    logic [BITS-1:0]     slot_d [NUM];
    logic [IdxW-1:0]     idx_q, idx_d;

    // Output stage
    logic                out_valid_q, out_valid_d;
    logic [NUM*BITS-1:0] out_data_q, out_data_d;
    logic [CntW-1:0]     out_count_q, out_count_d;
    logic                out_last_q, out_last_d;

    logic                s_ready;
    logic                accept;
    logic                complete;
    int unsigned         idx_u;

    always_comb begin
        s_ready  = resetn & (~out_valid_q | bus.out_ready);
        accept   = bus.s_valid & s_ready;
        complete = accept & ((idx_q == IdxW'(NUM - 1)) | bus.s_last);
        idx_u    = 32'(idx_q);

        slot_d      = slot_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;

        // Handshake drops valid; a group completing this same cycle overrides it below.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // The closing operand goes straight to the output register, never to a slot.
                for (int unsigned i = 0; i < NUM; i++) begin
                    if (i < idx_u) begin
                        out_data_d[(NUM-1-i)*BITS +: BITS] = slot_q[i];
                    end else if (i == idx_u) begin
                        out_data_d[(NUM-1-i)*BITS +: BITS] = bus.s_data;
                    end else begin
                        out_data_d[(NUM-1-i)*BITS +: BITS] = PAD_VALUE;
                    end
                end
                out_valid_d = 1'b1;
                out_count_d = CntW'(idx_q) + CntW'(1);
                out_last_d  = bus.s_last;
                idx_d       = '0;
            end else begin
                slot_d[idx_q] = bus.s_data;
                idx_d         = idx_q + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                slot_q[i] <= '0;
            end
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_adder_operand_packer.sv
module tb_adder_operand_packer;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    adder_operand_packer_if #(.BITS(16), .NUM(4)) bus ();

    adder_operand_packer #(
        .BITS      (16),
        .NUM       (4),
        .PAD_VALUE (16'h0000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed per-cycle vectors: inputs for one cycle, s_ready expected before the edge,
    // group outputs expected after the edge (data/count/last only checked when valid).
    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        ordy;
        logic        sr;
        logic        ov;
        logic [63:0] data;
        logic [2:0]  cnt;
        logic        last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [15:0] d, input logic l, input logic ordy,
                       input logic sr, input logic ov, input logic [63:0] data,
                       input logic [2:0] cnt, input logic last);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ordy = ordy; r.sr = sr;
        r.ov = ov; r.data = data; r.cnt = cnt; r.last = last;
        vecs.push_back(r);
    endtask

    // Reference model state for sequence and random phases.
    logic        m_ov   = 1'b0;
    logic [63:0] m_data = '0;
    logic [2:0]  m_cnt  = '0;
    logic        m_last = 1'b0;
    logic [15:0] m_ops[$];

    task automatic mstep(input logic rstn, input logic v, input logic [15:0] d, input logic l,
                         input logic ordy);
        logic exp_sr;
        logic acc;
        resetn        = rstn;
        bus.s_valid   = v;
        bus.s_data    = d;
        bus.s_last    = l;
        bus.out_ready = ordy;
        #1;
        exp_sr = rstn & (~m_ov | ordy);
        chk("s_ready", 64'(bus.s_ready), 64'(exp_sr));
        @(posedge clk);
        if (!rstn) begin
            m_ov = 1'b0; m_data = '0; m_cnt = '0; m_last = 1'b0;
            m_ops.delete();
        end else begin
            acc = v & exp_sr;
            if (m_ov && ordy) m_ov = 1'b0;
            if (acc) begin
                m_ops.push_back(d);
                if (m_ops.size() == 4 || l) begin
                    m_data = '0;
                    for (int k = 0; k < 4; k++) begin
                        m_data = {m_data[47:0], (k < m_ops.size()) ? m_ops[k] : 16'h0000};
                    end
                    m_cnt  = 3'(m_ops.size());
                    m_last = l;
                    m_ov   = 1'b1;
                    m_ops.delete();
                end
            end
        end
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        if (m_ov || !rstn) begin
            chk("out_data", bus.out_data, m_data);
            chk("out_count", 64'(bus.out_count), 64'(m_cnt));
            chk("out_last", 64'(bus.out_last), 64'(m_last));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        resetn        = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("reset s_ready", 64'(bus.s_ready), 64'd0);
        @(posedge clk); #1;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", bus.out_data, 64'd0);
        chk("reset out_count", 64'(bus.out_count), 64'd0);
        chk("reset out_last", 64'(bus.out_last), 64'd0);
        resetn = 1'b1;

        // Full group back-to-back
        add(1, 16'h36ac, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h39c3, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h077f, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h34d6, 0, 1, 1, 1, 64'h36ac_39c3_077f_34d6, 4, 0);
        add(0, 16'h0000, 0, 1, 1, 0, 64'h0, 0, 0);
        // Short group closed by s_last, ignored s_last bubble, s_last on first operand
        add(1, 16'h3659, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h384f, 1, 1, 1, 1, 64'h3659_384f_0000_0000, 2, 1);
        add(0, 16'hffff, 1, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'haaaa, 1, 1, 1, 1, 64'haaaa_0000_0000_0000, 1, 1);
        add(0, 16'h0000, 0, 1, 1, 0, 64'h0, 0, 0);
        // Backpressure hold, then resume without loss
        add(1, 16'h5001, 0, 0, 1, 0, 64'h0, 0, 0);
        add(1, 16'h5002, 0, 0, 1, 0, 64'h0, 0, 0);
        add(1, 16'h5003, 0, 0, 1, 0, 64'h0, 0, 0);
        add(1, 16'h5004, 0, 0, 1, 1, 64'h5001_5002_5003_5004, 4, 0);
        for (int i = 0; i < 5; i++) add(1, 16'hdead, 0, 0, 0, 1, 64'h5001_5002_5003_5004, 4, 0);
        add(1, 16'h6001, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h6002, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h6003, 0, 1, 1, 0, 64'h0, 0, 0);
        add(1, 16'h6004, 0, 1, 1, 1, 64'h6001_6002_6003_6004, 4, 0);
        // Handshake and group completion in the same cycle keep out_valid high
        add(1, 16'h7001, 1, 1, 1, 1, 64'h7001_0000_0000_0000, 1, 1);
        add(0, 16'h0000, 0, 1, 1, 0, 64'h0, 0, 0);

        foreach (vecs[n]) begin
            bus.s_valid   = vecs[n].v;
            bus.s_data    = vecs[n].d;
            bus.s_last    = vecs[n].l;
            bus.out_ready = vecs[n].ordy;
            #1;
            chk($sformatf("vec%0d s_ready", n), 64'(bus.s_ready), 64'(vecs[n].sr));
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", n), 64'(bus.out_valid), 64'(vecs[n].ov));
            if (vecs[n].ov) begin
                chk($sformatf("vec%0d out_data", n), bus.out_data, vecs[n].data);
                chk($sformatf("vec%0d out_count", n), 64'(bus.out_count), 64'(vecs[n].cnt));
                chk($sformatf("vec%0d out_last", n), 64'(bus.out_last), 64'(vecs[n].last));
            end
        end

        // Streaming: 16 consecutive operands -> 4 groups
        mstep(0, 0, 16'h0, 0, 1);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            mstep(1, 1, 16'(16'h1000 + i), 0, 1);
            if (bus.out_valid) pulses++;
        end
        chk("stream group pulses", 64'(pulses), 64'd4);
        mstep(1, 0, 16'h0, 0, 1);

        // Reset mid-group discards the partial group
        mstep(1, 1, 16'h1111, 0, 1);
        mstep(1, 1, 16'h2222, 0, 1);
        mstep(0, 1, 16'h9999, 0, 1);
        mstep(1, 1, 16'h328b, 0, 1);
        mstep(1, 1, 16'h3b06, 0, 1);
        mstep(1, 1, 16'h2703, 0, 1);
        mstep(1, 1, 16'h395d, 0, 1);
        chk("post-reset group", bus.out_data, 64'h328b_3b06_2703_395d);
        chk("post-reset count", 64'(bus.out_count), 64'd4);

        // Random bubbles, s_last and backpressure
        for (int i = 0; i < 400; i++) begin
            mstep(1, ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
